tqvp_multi_adder: RTL and testbench
===================================

Name: tqvp_multi_adder

Overview:
- Parametrised multi-operand add/accumulate peripheral for the TinyQV peripheral bus.
- Holds NUM_OPS operand registers of WIDTH bits and, on a start command, sums them sequentially (one operand per cycle) into a WIDTH+8-bit result/accumulator.
- Supports sum, accumulate and subtract modes, a hardware start pin and a done interrupt.

Parameters:
- WIDTH, 32: operand width in bits; 8, 16, 24 or 32.
- NUM_OPS, 4: number of operand registers; 2..8.

Ports:
- clk  in  1  project clock (64 MHz).
- rst  in  1  synchronous, active-high reset.
- ui_in  in  8  input PMOD, already synchronised; ui_in[6] is the hardware start.
- uo_out  out  8  RESULT[7:0].
- address  in  6  register address.
- data_in  in  32  write data; bottom 8/16/32 bits valid.
- data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit.
- data_read_n  in  2  11 none, else read size; unused.
- data_out  out  32  read data.
- data_ready  out  1  tied to 1; all reads complete in 1 cycle.
- user_interrupt  out  1  done interrupt.

Behaviour:
- Register map (RW = WIDTH+8):
  - 0x00 + 4n: OPn, n < NUM_OPS.
  - 0x20 CTRL: [0] start, write-1 self-clearing, reads 0; [2:1] mode (00 sum, 01 accumulate, 10 subtract, 11 treated as sum); [3] irq_en.
  - 0x24 STATUS, RO: [0] busy; [1] done; [2] sat (0 unless TQVP_MADD_SAT_EN).
  - 0x28 RESULT[31:0].
  - 0x2C RESULT[RW-1:32] zero-extended. Reads 0 if RW ≤ 32.
  - 0x30 CLEAR, W1: [0] clears done and irq; [1] clears RESULT.
  - Any other address reads 0.
- Writes use byte lanes:
  - byte 0 on any write;
  - bits 15:8 on 16- or 32-bit writes;
  - bits 31:16 on 32-bit writes only.
  - OP bits at or above WIDTH are dropped and read back as 0.
- Reset values: all OPn, CTRL, RESULT, done, sat and irq are 0; state IDLE; uo_out = 0.
- FSM IDLE → RUN → IDLE:
  - A start is accepted in IDLE on either a CTRL write with data_in[0]=1, or a rising edge of ui_in[6] (a 1-cycle-delayed copy is compared).
  - In the accept cycle T: idx ← 0; done and irq clear.
  - Working register W is loaded as:
    - sum: 0;
    - accumulate: RESULT;
    - subtract: 0.
  - RUN, cycles T+1..T+NUM_OPS:
    - W ← W + zext(OP[idx]) for sum/accumulate;
    - in subtract, idx 0 adds and later indices subtract;
    - arithmetic is modulo 2^RW;
    - idx increments each cycle.
  - Last RUN cycle: RESULT ← W; done ← 1; return to IDLE.
  - busy = 1 exactly for cycles T+1..T+NUM_OPS.
  - RESULT and done are visible from T+NUM_OPS+1.
  - Mode is latched at accept; CTRL mode writes during RUN affect only the next operation.
- While busy:
  - Starts are ignored and not queued.
  - OPn writes and CLEAR[1] are ignored.
  - CLEAR[0] still acts.
- IRQ: set on the done-setting cycle if irq_en. Cleared by CLEAR[0] or by a new accept. If set and clear coincide, set wins.
- Reset asserted mid-RUN: the operation is abandoned, all state returns to reset values, and no done or irq is generated.

Optional Feature:
- Macro: TQVP_MADD_SAT_EN.
- Defined: at completion in sum and accumulate modes, if W > 2^WIDTH−1 then RESULT ← 2^WIDTH−1 and sat ← 1. In subtract mode, if W is negative (bit RW−1 set) then RESULT ← 0 and sat ← 1. Otherwise sat ← 0.
- Undefined: results wrap modulo 2^RW and sat reads 0.

Decomposition:
- Package tqvp_madd_pkg:
  - register address constants;
  - mode encoding constants (MODE_SUM, MODE_ACC, MODE_SUB);
  - FSM state encoding;
  - RW derivation.
- One sub-module, tqvp_madd_opbank: the NUM_OPS×WIDTH operand register file with byte-lane write decode, a busy write-block, and an idx read mux.

Test Plan (WIDTH=32, NUM_OPS=4):
- OP0..3 = 1,2,3,4; sum start at T → busy high T+1..T+4; RESULT=10 and done=1 at T+5; uo_out=0x0A.
- OP0..3 = 0xFFFFFFFF; sum → 0x28 reads 0xFFFFFFFC and 0x2C reads 0x03. With TQVP_MADD_SAT_EN: 0xFFFFFFFF with sat=1.
- Previous RESULT 10, ops 1,2,3,4, accumulate → 20. Subtract with ops 10,1,2,3 → 4. Subtract with 0,1,0,0 → 0xFF_FFFFFFFF wrap, or 0 with sat=1 when the feature is on.
- Start at T, then a second start plus a write OP0=99 at T+2 → second start and write ignored; RESULT=10; OP0 still 1.
- irq_en=1, ui_in[6] 0→1 → start accepted; irq high at completion. CLEAR[0] write in the same cycle done sets → irq stays 1; a later CLEAR[0] → 0.
- rst pulsed at T+2 mid-RUN → busy=0, done=0, irq=0, RESULT=0, OPn=0.

Source files
------------

// File: rtl/tqvp_madd_pkg.sv
// tqvp_madd_pkg: shared constants, FSM encoding and helpers for the multi-operand adder.
package tqvp_madd_pkg;
    localparam logic [5:0] A_CTRL   = 6'h20;
    localparam logic [5:0] A_STATUS = 6'h24;
    localparam logic [5:0] A_RES_LO = 6'h28;
    localparam logic [5:0] A_RES_HI = 6'h2C;
    localparam logic [5:0] A_CLEAR  = 6'h30;
    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_ACC = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    function automatic int rw_of(input int width);
        return width + 8;
    endfunction
    // Byte 0 always lands; 16/32-bit writes add byte 1; only 32-bit writes reach the top half.
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d, input logic [1:0] wn);
        lane_merge = old;
        lane_merge[7:0] = d[7:0];
        if (wn != 2'b00) lane_merge[15:8] = d[15:8];
        if (wn == 2'b10) lane_merge[31:16] = d[31:16];
    endfunction
endpackage

// File: rtl/tqvp_multi_adder_if.sv
// tqvp_multi_adder_if: TinyQV peripheral register bus.
interface tqvp_multi_adder_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    modport master (output address, data_in, data_write_n, data_read_n, input data_out, data_ready);
    modport slave (input address, data_in, data_write_n, data_read_n, output data_out, data_ready);
endinterface

// File: rtl/tqvp_madd_opbank.sv
// tqvp_madd_opbank: operand register file with byte-lane writes, busy write-block and idx read mux.
module tqvp_madd_opbank
    import tqvp_madd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM_OPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       address,
    input  logic [31:0]      data_in,
    input  logic [1:0]       data_write_n,
    input  logic             busy,
    input  logic [2:0]       idx,
    output logic [WIDTH-1:0] op,
    output logic [31:0]      rd_data
);
    logic [WIDTH-1:0] ops [NUM_OPS];
    logic             we;
    assign we = !busy && data_write_n != 2'b11;
    always_ff @(posedge clk)
        for (int k = 0; k < NUM_OPS; k++)
            if (rst) ops[k] <= '0;
            else if (we && address == 6'(4 * k)) ops[k] <= WIDTH'(lane_merge(32'(ops[k]), data_in, data_write_n));
    always_comb begin
        op = '0;
        rd_data = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (idx == 3'(k)) op = ops[k];
            if (address == 6'(4 * k)) rd_data = 32'(ops[k]);
        end
    end
endmodule

// File: rtl/tqvp_multi_adder.sv
// tqvp_multi_adder: sequential multi-operand sum/accumulate/subtract peripheral with done interrupt.
// Define TQVP_MADD_SAT_EN to clamp completed results and report saturation in STATUS[2].
module tqvp_multi_adder
    import tqvp_madd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM_OPS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          ui_in,
    output logic [7:0]          uo_out,
    tqvp_multi_adder_if.slave   bus,
    output logic                user_interrupt
);
    localparam int RW = rw_of(WIDTH);
    state_t          state, state_n;
    logic [2:0]      idx;
    logic [RW-1:0]   w, w_next, result, res_fin;
    logic [1:0]      mode, mode_q, mode_in;
    logic            irq_en, done, sat, sat_hit, irq, ui6_q;
    logic            wr_en, busy, sw_start, hw_start, accept, last, ctrl_wr, clr_wr;
    logic [WIDTH-1:0] op;
    logic [31:0]     op_rd;
    logic [63:0]     r64;
    logic            unused_ok;
    tqvp_madd_opbank #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) u_opbank (
        .clk, .rst, .address(bus.address), .data_in(bus.data_in), .data_write_n(bus.data_write_n),
        .busy, .idx, .op, .rd_data(op_rd)
    );
    assign wr_en    = bus.data_write_n != 2'b11;
    assign busy     = state == S_RUN;
    assign ctrl_wr  = wr_en && bus.address == A_CTRL;
    assign clr_wr   = wr_en && bus.address == A_CLEAR;
    assign sw_start = ctrl_wr && bus.data_in[0];
    assign hw_start = ui_in[6] && !ui6_q;
    assign mode_in  = sw_start ? bus.data_in[2:1] : mode;
    assign w_next   = (mode_q == MODE_SUB && idx != 3'd0) ? w - RW'(op) : w + RW'(op);
`ifdef TQVP_MADD_SAT_EN
    assign sat_hit = mode_q == MODE_SUB ? w_next[RW-1] : |(w_next >> WIDTH);
    assign res_fin = !sat_hit ? w_next : mode_q == MODE_SUB ? '0 : RW'({WIDTH{1'b1}});
`else
    assign sat_hit = 1'b0;
    assign res_fin = w_next;
`endif
    always_comb begin
        accept  = state == S_IDLE && (sw_start || hw_start);
        last    = state == S_RUN && idx == 3'(NUM_OPS - 1);
        state_n = accept ? S_RUN : last ? S_IDLE : state;
    end
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            w <= '0;
            result <= '0;
            mode <= MODE_SUM;
            mode_q <= MODE_SUM;
            irq_en <= 1'b0;
            done <= 1'b0;
            sat <= 1'b0;
            irq <= 1'b0;
            ui6_q <= 1'b0;
        end else begin
            ui6_q <= ui_in[6];
            if (ctrl_wr) {irq_en, mode} <= bus.data_in[3:1];
            if (clr_wr && bus.data_in[0]) begin
                done <= 1'b0;
                irq <= 1'b0;
            end
            if (clr_wr && bus.data_in[1] && !busy) result <= '0;
            if (accept) begin
                idx <= '0;
                w <= mode_in == MODE_ACC ? result : '0;
                mode_q <= (mode_in == MODE_ACC || mode_in == MODE_SUB) ? mode_in : MODE_SUM;
                done <= 1'b0;
                irq <= 1'b0;
            end
            if (busy) begin
                w <= w_next;
                idx <= idx + 3'd1;
            end
            // Completion comes after the clear so a coinciding CLEAR[0] loses.
            if (last) begin
                result <= res_fin;
                sat <= sat_hit;
                done <= 1'b1;
                if (irq_en) irq <= 1'b1;
            end
        end
    end
    assign r64 = 64'(result);
    always_comb
        bus.data_out = bus.address == A_CTRL   ? {28'b0, irq_en, mode, 1'b0} :
                       bus.address == A_STATUS ? {29'b0, sat, done, busy} :
                       bus.address == A_RES_LO ? r64[31:0] :
                       bus.address == A_RES_HI ? r64[63:32] : op_rd;
    assign bus.data_ready = 1'b1;
    assign uo_out = result[7:0];
    assign user_interrupt = irq;
    assign unused_ok = &{1'b0, bus.data_read_n, ui_in[7], ui_in[5:0]};
endmodule

// File: tb/tb_tqvp_multi_adder.sv
// tb_tqvp_multi_adder: directed scoreboard bench for the multi-operand adder (WIDTH=32, NUM_OPS=4).
module tb_tqvp_multi_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic       user_interrupt;
    int         errors = 0;
    int         checks = 0;
    logic [39:0] sbq[$];
    logic [31:0] rv, rh;
    tqvp_multi_adder_if bus ();
    tqvp_multi_adder #(.WIDTH(32), .NUM_OPS(4)) dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .bus(bus.slave), .user_interrupt(user_interrupt)
    );
    always #5 clk = ~clk;
`ifdef TQVP_MADD_SAT_EN
    localparam logic [39:0] EXP_FULL = 40'h00_FFFFFFFF;
    localparam logic [39:0] EXP_NEG  = 40'h0;
    localparam logic        EXP_SAT  = 1'b1;
`else
    localparam logic [39:0] EXP_FULL = 40'h03_FFFFFFFC;
    localparam logic [39:0] EXP_NEG  = 40'hFF_FFFFFFFF;
    localparam logic        EXP_SAT  = 1'b0;
`endif
    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b10);
        @(negedge clk);
        bus.address = a;
        bus.data_in = d;
        bus.data_write_n = wn;
        @(negedge clk);
        bus.data_write_n = 2'b11;
        bus.address = 6'h24;
    endtask
    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        #1 d = bus.data_out;
    endtask
    task automatic set_ops(input logic [31:0] a, b, c, d);
        wr(6'h00, a);
        wr(6'h04, b);
        wr(6'h08, c);
        wr(6'h0C, d);
    endtask
    task automatic wait_done();
        logic [31:0] s;
        int n = 0;
        do begin
            @(negedge clk);
            rd(6'h24, s);
            n++;
        end while (!s[1] && n < 30);
        check("done_wait", 40'(s[1]), 40'd1);
    endtask
    task automatic check_result(input string tag);
        logic [31:0] lo, hi;
        rd(6'h28, lo);
        rd(6'h2C, hi);
        check(tag, {hi[7:0], lo}, sbq.pop_front());
    endtask
    task automatic run_check(input string tag, input logic [1:0] mode, input logic [39:0] exp, input bit poke = 0);
        sbq.push_back(exp);
        wr(6'h20, {28'b0, 1'b0, mode, 1'b1});
        if (poke) wr(6'h20, 32'h0);
        wait_done();
        check_result(tag);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        bus.address = 6'h24;
        bus.data_in = '0;
        bus.data_write_n = 2'b11;
        bus.data_read_n = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(6'h24, rv);
        check("rst_status", rv, 0);
        rd(6'h28, rv);
        check("rst_result", rv, 0);
        rd(6'h20, rv);
        check("rst_ctrl", rv, 0);
        check("rst_uo_irq", {uo_out, user_interrupt}, 0);
        wr(6'h0C, 32'hAABBCCDD);
        wr(6'h0C, 32'h00000011, 2'b00);
        rd(6'h0C, rv);
        check("lane8", rv, 32'hAABBCC11);
        wr(6'h0C, 32'hFFFF2233, 2'b01);
        rd(6'h0C, rv);
        check("lane16", rv, 32'hAABB2233);
        set_ops(1, 2, 3, 4);
        rd(6'h08, rv);
        check("op2_rb", rv, 3);
        // Cycle-exact sum: busy for T+1..T+4, done at T+5.
        sbq.push_back(40'd10);
        wr(6'h20, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            rd(6'h24, rv);
            check($sformatf("busy_T%0d", k), rv[1:0], 2'b01);
            @(negedge clk);
        end
        rd(6'h24, rv);
        check("status_T5", rv, 32'h2);
        check_result("sum_1234");
        check("uo_out", uo_out, 8'h0A);
        check("no_irq", user_interrupt, 0);
        run_check("acc", 2'b01, 40'd20);
        set_ops(10, 1, 2, 3);
        run_check("sub_latch", 2'b10, 40'd4, 1);
        rd(6'h20, rv);
        check("ctrl_after_poke", rv, 0);
        set_ops(0, 1, 0, 0);
        run_check("sub_neg", 2'b10, EXP_NEG);
        rd(6'h24, rv);
        check("sat_neg", rv[2], EXP_SAT);
        set_ops(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_check("sum_full", 2'b00, EXP_FULL);
        rd(6'h24, rv);
        check("sat_full", rv[2], EXP_SAT);
        // Starts and operand writes during RUN are ignored.
        set_ops(1, 2, 3, 4);
        sbq.push_back(40'd10);
        wr(6'h20, 32'h1);
        wr(6'h00, 32'd99);
        wr(6'h20, 32'h1);
        wait_done();
        check_result("busy_ignore");
        repeat (3) @(negedge clk);
        rd(6'h24, rv);
        check("no_queued_start", rv[0], 0);
        rd(6'h00, rv);
        check("op0_kept", rv, 1);
        wr(6'h30, 32'h2);
        rd(6'h28, rv);
        check("clear_result", rv, 0);
        // Hardware start with irq; CLEAR[0] coincides with the done-setting cycle.
        wr(6'h20, 32'h8);
        sbq.push_back(40'd10);
        @(negedge clk);
        ui_in[6] = 1'b1;
        repeat (4) @(negedge clk);
        bus.address = 6'h30;
        bus.data_in = 32'h1;
        bus.data_write_n = 2'b10;
        @(negedge clk);
        bus.data_write_n = 2'b11;
        check("irq_set_wins", user_interrupt, 1);
        rd(6'h24, rv);
        check("done_set_wins", rv[1:0], 2'b10);
        check_result("hw_start");
        wr(6'h30, 32'h1);
        check("irq_cleared", user_interrupt, 0);
        rd(6'h24, rv);
        check("hw_no_retrigger", rv, 0);
        ui_in[6] = 1'b0;
        // Reset in the middle of RUN abandons everything.
        wr(6'h20, 32'h9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        rd(6'h24, rv);
        check("rst_mid_status", rv, 0);
        check("rst_mid_irq", user_interrupt, 0);
        rd(6'h28, rv);
        check("rst_mid_result", rv, 0);
        rd(6'h00, rv);
        rd(6'h0C, rh);
        check("rst_mid_ops", {rv, rh[7:0]}, 0);
        check("sb_empty", 40'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
